// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity) framing.
module uart_tx #(
    parameter int BAUD_DIV   = 217,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        srst_n_i,
    input  logic                        wr_i,
    input  logic [7:0]                  wdata_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        busy_o,
    output logic                        tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     level_q, level_d;
    logic            full_q, empty_q, busy_q, tx_q, tx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sh_q, sh_d, head;
    logic [2:0]      bit_q, bit_d;
    logic            push, pop, last;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    assign head    = mem_q[rptr_q];
    assign push    = wr_i && !full_q;
    assign last    = cnt_q == '0;
    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
    assign busy_o  = busy_q;
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) cnt_d = last ? RELOAD : cnt_q - CW'(1);
        case (state_q)
            IDLE:  pop = !empty_q;
            START: if (last) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (last) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) state_d = STOP;
`endif
            STOP: if (last) begin
                pop     = !empty_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a pop always starts a new frame, from IDLE or straight out of STOP
        if (pop) begin
            state_d = START;
            cnt_d   = RELOAD;
            sh_d    = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
`ifdef UART_TX_PARITY_EN
        tx_d = state_d == PARITY ? par_d : 1'b1;
`else
        tx_d = 1'b1;
`endif
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : tx_d;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            wptr_q  <= wptr_q + AW'(push);
            rptr_q  <= rptr_q + AW'(pop);
            level_q <= level_d;
            full_q  <= level_d == DEPTH;
            empty_q <= level_d == '0;
            busy_q  <= state_d != IDLE;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a serial-line scoreboard monitor for uart_tx (BAUD_DIV=4, FIFO_DEPTH=8).
module tb_uart_tx;
    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * BD;

    logic       clk = 1'b0, srst_n = 1'b0, wr = 1'b0;
    logic [7:0] wdata = '0;
    logic       full, empty, busy, tx;
    logic [3:0] level;
    int         checks = 0, failures = 0, gen = 0;
    logic [8:0] exp_q[$];

    uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .srst_n_i(srst_n), .wr_i(wr), .wdata_i(wdata),
        .full_o(full), .empty_o(empty), .level_o(level), .busy_o(busy), .tx_o(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit track);
        wr = 1'b1;
        wdata = b;
        if (track) exp_q.push_back({^b, b});
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(empty === 1'b1 && busy === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 2000), 1);
        repeat (4) @(negedge clk);
    endtask

    // cycle k after a write at cycle 0: start bit on 2..5, data LSB first, then parity/stop
    task automatic frame_check(input logic [7:0] b, input logic p);
        int i;
        logic e;
        write_byte(b, 1'b1);
        for (int k = 1; k <= 2 + F; k++) begin
            if (k < 2 || k >= 2 + F) e = 1'b1;
            else begin
                i = (k - 2) / BD;
                e = i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (i == 9 && NB == 11) ? p : 1'b1;
            end
            check("frame_tx", tx, e);
            check("frame_busy", busy, 32'(k >= 2 && k < 2 + F));
            if (k == 1) begin
                check("frame_level_n1", level, 1);
                check("frame_empty_n1", empty, 0);
            end
            if (k == 2) check("frame_level_n2", level, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s, st;
        int         g;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (srst_n && tx === 1'b0) begin
                g = gen;
                repeat (BD / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    d[i] = tx;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (BD) @(negedge clk);
                p = tx;
`endif
                repeat (BD) @(negedge clk);
                s = tx;
                if (g == gen) begin
                    check("mon_start", st, 0);
                    check("mon_stop", s, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected: got frame %0h expected none", d);
                    end else begin
                        e = exp_q.pop_front();
                        check("mon_data", d, e[7:0]);
`ifdef UART_TX_PARITY_EN
                        check("mon_parity", p, e[8]);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        srst_n = 1'b1;
        @(negedge clk);

        frame_check(8'h55, 1'b0);
        wait_idle();
`ifdef UART_TX_PARITY_EN
        frame_check(8'h07, 1'b1);
        wait_idle();
        frame_check(8'h03, 1'b0);
        wait_idle();
`endif

        write_byte(8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            w = 8'(8'h10 + i);
            wr = 1'b1;
            wdata = w;
            if (i < 8) exp_q.push_back({^w, w});
            @(negedge clk);
            if (i == 6) begin
                check("ovf_full_7", full, 0);
                check("ovf_level_7", level, 7);
            end
            if (i >= 7) begin
                check("ovf_full", full, 1);
                check("ovf_level", level, 8);
            end
        end
        wr = 1'b0;
        wait_idle();
        check("ovf_empty", empty, 1);
        check("ovf_drained", exp_q.size(), 0);

        write_byte(8'hA5, 1'b1);
        write_byte(8'h3C, 1'b1);
        begin
            int gap = 0;
            for (int k = 2; k <= 2 + 2 * F; k++) begin
                if (k < 2 + 2 * F && busy !== 1'b1) gap++;
                if (k == 1 + F) check("b2b_stop1", tx, 1);
                if (k == 2 + F) check("b2b_start2", tx, 0);
                if (k == 2 + 2 * F) check("b2b_busy_end", busy, 0);
                @(negedge clk);
            end
            check("b2b_no_gap", gap, 0);
        end
        wait_idle();

        write_byte(8'h20, 1'b1);
        write_byte(8'h21, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h23, 1'b1);
        check("pp_level_3", level, 3);
        repeat (F - 3) @(negedge clk);
        check("pp_level_before", level, 3);
        write_byte(8'h24, 1'b1);
        check("pp_level_after", level, 3);
        check("pp_next_start", tx, 0);
        wait_idle();
        check("pp_drained", exp_q.size(), 0);

        write_byte(8'h0F, 1'b0);
        write_byte(8'h33, 1'b0);
        repeat (17) @(negedge clk);
        srst_n = 1'b0;
        gen++;
        @(negedge clk);
        srst_n = 1'b1;
        check("mrst_tx", tx, 1);
        check("mrst_busy", busy, 0);
        check("mrst_level", level, 0);
        check("mrst_empty", empty, 1);
        repeat (50) @(negedge clk);
        write_byte(8'hFF, 1'b1);
        wait_idle();

        repeat (10) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
